core_decode_stage: RTL and testbench

- Q102H decode stage of the simple core: sits between fetch (Q101H) and execute (Q103H).
- Accepts fetched instructions over a valid/ready handshake and decodes them into core_pkg types (t_opcode, t_immediate, t_alu_op, t_branch_type).
- Generates the sign-extended immediate and reads rs1/rs2 from an internal 32x32 register file, which is written back from Q105H with same-cycle bypass.
- Results are held in a stallable, flushable pipeline register.

---
 rtl/core_pkg.sv | 84 ++++++++
 rtl/core_decode_stage_if.sv | 49 ++++
 rtl/core_rf.sv | 39 +++
 rtl/core_decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_core_decode_stage.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - decode types, decode control struct and shared constants for the core
package core_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        I_OP   = 7'b0010011,
        R_OP   = 7'b0110011,
        FENCE  = 7'b0001111,
        SYSCAL = 7'b1110011
    } t_opcode;

    typedef enum logic [2:0] {
        I_TYPE = 3'd0,
        S_TYPE = 3'd1,
        B_TYPE = 3'd2,
        U_TYPE = 3'd3,
        J_TYPE = 3'd4
    } t_immediate;

    // Encoded as {inst[30], funct3} so R/I ops map straight through
    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SLL  = 4'b0001,
        SLT  = 4'b0010,
        SLTU = 4'b0011,
        XOR  = 4'b0100,
        SRL  = 4'b0101,
        OR   = 4'b0110,
        AND  = 4'b0111,
        SUB  = 4'b1000,
        SRA  = 4'b1101,
        IN_2 = 4'b1111
    } t_alu_op;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } t_branch_type;

    typedef struct packed {
        t_opcode      opcode;
        t_immediate   imm_type;
        t_alu_op      alu_op;
        t_branch_type br_type;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic         reg_wr_en;
        logic         mem_rd_en;
        logic         mem_wr_en;
        logic         illegal;
    } t_decode_ctrl;

    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
            I_OP, R_OP, FENCE, SYSCAL: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // A write-back that lands on a source register this cycle; x0 never matches
    function automatic logic wb_match(input logic en, input logic [4:0] wr_idx,
                                      input logic [4:0] rs_idx);
        return en && (wr_idx == rs_idx) && (rs_idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/core_decode_stage_if.sv
// rtl/core_decode_stage_if.sv - fetch, decode-result and write-back signals of the decode stage
interface core_decode_stage_if;
    import core_pkg::*;

    logic                FetchValidQ101H;
    logic                FetchReadyQ101H;
    logic [XLEN-1:0]     FetchInstQ101H;
    logic [XLEN-1:0]     FetchPcQ101H;
    logic                FlushQ102H;
    logic                DecValidQ102H;
    logic                DecReadyQ103H;
    logic [XLEN-1:0]     DecPcQ102H;
    t_opcode             DecOpcodeQ102H;
    t_immediate          DecImmTypeQ102H;
    logic [XLEN-1:0]     DecImmQ102H;
    t_alu_op             DecAluOpQ102H;
    t_branch_type        DecBrTypeQ102H;
    logic [4:0]          DecRs1Q102H;
    logic [4:0]          DecRs2Q102H;
    logic [4:0]          DecRdQ102H;
    logic [XLEN-1:0]     DecRs1DataQ102H;
    logic [XLEN-1:0]     DecRs2DataQ102H;
    logic                DecRegWrEnQ102H;
    logic                DecMemRdEnQ102H;
    logic                DecMemWrEnQ102H;
    logic                DecIllegalQ102H;
    logic                WbEnQ105H;
    logic [4:0]          WbRdQ105H;
    logic [XLEN-1:0]     WbDataQ105H;

    modport master (
        output FetchValidQ101H, FetchInstQ101H, FetchPcQ101H, FlushQ102H, DecReadyQ103H,
               WbEnQ105H, WbRdQ105H, WbDataQ105H,
        input  FetchReadyQ101H, DecValidQ102H, DecPcQ102H, DecOpcodeQ102H, DecImmTypeQ102H,
               DecImmQ102H, DecAluOpQ102H, DecBrTypeQ102H, DecRs1Q102H, DecRs2Q102H,
               DecRdQ102H, DecRs1DataQ102H, DecRs2DataQ102H, DecRegWrEnQ102H,
               DecMemRdEnQ102H, DecMemWrEnQ102H, DecIllegalQ102H
    );

    modport slave (
        input  FetchValidQ101H, FetchInstQ101H, FetchPcQ101H, FlushQ102H, DecReadyQ103H,
               WbEnQ105H, WbRdQ105H, WbDataQ105H,
        output FetchReadyQ101H, DecValidQ102H, DecPcQ102H, DecOpcodeQ102H, DecImmTypeQ102H,
               DecImmQ102H, DecAluOpQ102H, DecBrTypeQ102H, DecRs1Q102H, DecRs2Q102H,
               DecRdQ102H, DecRs1DataQ102H, DecRs2DataQ102H, DecRegWrEnQ102H,
               DecMemRdEnQ102H, DecMemWrEnQ102H, DecIllegalQ102H
    );

endinterface

// File: rtl/core_rf.sv
// rtl/core_rf.sv - 32x32 register file, two async read ports, one write port, x0 hard zero
module core_rf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [4:0]      rd_addr_b,
    output logic [XLEN-1:0] rd_data_b
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    // Next array contents: one write per cycle, x0 is never stored
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != REG_ZERO)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/core_decode_stage.sv
// rtl/core_decode_stage.sv - Q102H decode stage; optional illegal-encoding check under CORE_DECODE_ILLEGAL_EN
module core_decode_stage
    import core_pkg::*;
(
    input  logic               Clk,
    input  logic               RstN,
    core_decode_stage_if.slave dec_if
);

    logic            adv;
    logic            load;
    logic [XLEN-1:0] inst;
    logic [2:0]      funct3;
    t_decode_ctrl    ctrl_c;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] rf_rd_a;
    logic [XLEN-1:0] rf_rd_b;

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    t_decode_ctrl    ctrl_q,     ctrl_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;

    assign adv    = !valid_q || dec_if.DecReadyQ103H;
    assign load   = adv && dec_if.FetchValidQ101H && !dec_if.FlushQ102H;
    assign inst   = dec_if.FetchInstQ101H;
    assign funct3 = inst[14:12];

    core_rf u_rf (
        .clk       (Clk),
        .rst_n     (RstN),
        .wr_en     (dec_if.WbEnQ105H),
        .wr_addr   (dec_if.WbRdQ105H),
        .wr_data   (dec_if.WbDataQ105H),
        .rd_addr_a (ctrl_c.rs1),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (ctrl_c.rs2),
        .rd_data_b (rf_rd_b)
    );

    // Decode the incoming instruction word into control fields and immediate
    always_comb begin
        ctrl_c          = '0;
        imm_c           = '0;
        ctrl_c.opcode   = t_opcode'(inst[6:0]);
        ctrl_c.br_type  = t_branch_type'(funct3);
        ctrl_c.rd       = inst[11:7];
        ctrl_c.rs1      = inst[19:15];
        ctrl_c.rs2      = inst[24:20];
        ctrl_c.imm_type = I_TYPE;
        ctrl_c.alu_op   = ADD;
        case (inst[6:0])
            LUI: begin
                ctrl_c.imm_type  = U_TYPE;
                ctrl_c.alu_op    = IN_2;
                ctrl_c.reg_wr_en = 1'b1;
                imm_c            = {inst[31:12], 12'h000};
            end
            AUIPC: begin
                ctrl_c.imm_type  = U_TYPE;
                ctrl_c.reg_wr_en = 1'b1;
                imm_c            = {inst[31:12], 12'h000};
            end
            JAL: begin
                ctrl_c.imm_type  = J_TYPE;
                ctrl_c.reg_wr_en = 1'b1;
                imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            JALR, LOAD: begin
                ctrl_c.reg_wr_en = 1'b1;
                ctrl_c.mem_rd_en = (inst[6:0] == LOAD);
                imm_c            = {{20{inst[31]}}, inst[31:20]};
            end
            I_OP: begin
                ctrl_c.reg_wr_en = 1'b1;
                ctrl_c.alu_op    = t_alu_op'({(funct3 == 3'b101) ? inst[30] : 1'b0, funct3});
                imm_c            = {{20{inst[31]}}, inst[31:20]};
            end
            R_OP: begin
                ctrl_c.reg_wr_en = 1'b1;
                ctrl_c.alu_op    = t_alu_op'({inst[30], funct3});
            end
            STORE: begin
                ctrl_c.imm_type  = S_TYPE;
                ctrl_c.mem_wr_en = 1'b1;
                imm_c            = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            BRANCH: begin
                ctrl_c.imm_type = B_TYPE;
                ctrl_c.alu_op   = SUB;
                imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            default: ;
        endcase
        if (ctrl_c.rd == REG_ZERO) begin
            ctrl_c.reg_wr_en = 1'b0;
        end
`ifdef CORE_DECODE_ILLEGAL_EN
        ctrl_c.illegal = (inst[1:0] != 2'b11) || !is_known_opcode(inst[6:0]);
        case (inst[6:0])
            R_OP:   if (!((inst[31:25] == 7'h00) ||
                          ((inst[31:25] == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                        ctrl_c.illegal = 1'b1;
            BRANCH: if ((funct3 == 3'b010) || (funct3 == 3'b011)) ctrl_c.illegal = 1'b1;
            LOAD:   if ((funct3 == 3'b011) || (funct3[2:1] == 2'b11)) ctrl_c.illegal = 1'b1;
            STORE:  if (funct3 > 3'b010) ctrl_c.illegal = 1'b1;
            default: ;
        endcase
        // Illegal encodings still decode but must not cause side effects downstream
        if (ctrl_c.illegal) begin
            ctrl_c.reg_wr_en = 1'b0;
            ctrl_c.mem_rd_en = 1'b0;
            ctrl_c.mem_wr_en = 1'b0;
        end
`endif
    end

    // Pipeline register next state: flush beats load, stall holds, held operands track write-back
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (dec_if.FlushQ102H) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = dec_if.FetchValidQ101H;
        end
        if (load) begin
            pc_d       = dec_if.FetchPcQ101H;
            ctrl_d     = ctrl_c;
            imm_d      = imm_c;
            rs1_data_d = wb_match(dec_if.WbEnQ105H, dec_if.WbRdQ105H, ctrl_c.rs1) ?
                         dec_if.WbDataQ105H : rf_rd_a;
            rs2_data_d = wb_match(dec_if.WbEnQ105H, dec_if.WbRdQ105H, ctrl_c.rs2) ?
                         dec_if.WbDataQ105H : rf_rd_b;
        end else begin
            if (wb_match(dec_if.WbEnQ105H, dec_if.WbRdQ105H, ctrl_q.rs1)) rs1_data_d = dec_if.WbDataQ105H;
            if (wb_match(dec_if.WbEnQ105H, dec_if.WbRdQ105H, ctrl_q.rs2)) rs2_data_d = dec_if.WbDataQ105H;
        end
    end

    // Pipeline register
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            ctrl_q     <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign dec_if.FetchReadyQ101H = adv;
    assign dec_if.DecValidQ102H   = valid_q;
    assign dec_if.DecPcQ102H      = pc_q;
    assign dec_if.DecOpcodeQ102H  = ctrl_q.opcode;
    assign dec_if.DecImmTypeQ102H = ctrl_q.imm_type;
    assign dec_if.DecImmQ102H     = imm_q;
    assign dec_if.DecAluOpQ102H   = ctrl_q.alu_op;
    assign dec_if.DecBrTypeQ102H  = ctrl_q.br_type;
    assign dec_if.DecRs1Q102H     = ctrl_q.rs1;
    assign dec_if.DecRs2Q102H     = ctrl_q.rs2;
    assign dec_if.DecRdQ102H      = ctrl_q.rd;
    assign dec_if.DecRs1DataQ102H = rs1_data_q;
    assign dec_if.DecRs2DataQ102H = rs2_data_q;
    assign dec_if.DecRegWrEnQ102H = ctrl_q.reg_wr_en;
    assign dec_if.DecMemRdEnQ102H = ctrl_q.mem_rd_en;
    assign dec_if.DecMemWrEnQ102H = ctrl_q.mem_wr_en;
    assign dec_if.DecIllegalQ102H = ctrl_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// tb/tb_core_decode_stage.sv - self-checking bench for core_decode_stage
module tb_core_decode_stage;
    import core_pkg::*;

`ifdef CORE_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_decode_stage_if dif();

    core_decode_stage u_dut (
        .Clk    (clk),
        .RstN   (rst_n),
        .dec_if (dif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural registers plus the instruction held in Q102H
    logic [31:0] rf_m [32];
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = 32'h0;
    logic [31:0] m_pc    = 32'h0;

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v << (32 - n);
        return 32'($signed(r) >>> (32 - n));
    endfunction

    function automatic logic [2:0] ref_immt(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:        return U_TYPE;
            7'h6F:               return J_TYPE;
            7'h23:               return S_TYPE;
            7'h63:               return B_TYPE;
            default:             return I_TYPE;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:        return i & 32'hFFFF_F000;
            7'h6F:               return sext({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            7'h67, 7'h03, 7'h13: return sext({20'h0, i[31:20]}, 12);
            7'h23:               return sext({20'h0, i[31:25], i[11:7]}, 12);
            7'h63:               return sext({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [31:0] i);
        case (i[6:0])
            7'h33:   return {i[30], i[14:12]};
            7'h13:   return {(i[14:12] == 3'd5) & i[30], i[14:12]};
            7'h37:   return IN_2;
            7'h63:   return SUB;
            default: return ADD;
        endcase
    endfunction

    function automatic logic ref_bad_enc(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        if (i[1:0] != 2'b11) return 1'b1;
        case (i[6:0])
            7'h33:   return !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'h63:   return (f3 == 3'd2) || (f3 == 3'd3);
            7'h03:   return (f3 == 3'd3) || (f3 >= 3'd6);
            7'h23:   return f3 > 3'd2;
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h0F, 7'h73: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        return ILL_EN && ref_bad_enc(i);
    endfunction

    function automatic logic ref_wr(input logic [31:0] i);
        return (i[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) &&
               (i[11:7] != 5'd0) && !ref_ill(i);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = ops[k];
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic set_idle();
        dif.FetchValidQ101H = 1'b0;
        dif.FetchInstQ101H  = 32'h0;
        dif.FetchPcQ101H    = 32'h0;
        dif.FlushQ102H      = 1'b0;
        dif.DecReadyQ103H   = 1'b1;
        dif.WbEnQ105H       = 1'b0;
        dif.WbRdQ105H       = 5'd0;
        dif.WbDataQ105H     = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        dif.FetchValidQ101H = 1'b1;
        dif.FetchInstQ101H  = inst;
        dif.FetchPcQ101H    = pc;
    endtask

    // Advance the reference by one clock from the inputs currently applied, then clock the DUT
    task automatic tick();
        logic adv;
        adv = !m_valid || dif.DecReadyQ103H;
        if (!dif.FlushQ102H && adv && dif.FetchValidQ101H) begin
            m_inst = dif.FetchInstQ101H;
            m_pc   = dif.FetchPcQ101H;
        end
        if (dif.FlushQ102H)  m_valid = 1'b0;
        else if (adv)        m_valid = dif.FetchValidQ101H;
        if (dif.WbEnQ105H && dif.WbRdQ105H != 5'd0) rf_m[dif.WbRdQ105H] = dif.WbDataQ105H;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [163:0] got;
        n_cmp++;
        if (dif.DecValidQ102H !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got %b exp 0", dif.DecValidQ102H);
        end
        got = {dif.DecPcQ102H, dif.DecOpcodeQ102H, dif.DecImmTypeQ102H, dif.DecImmQ102H,
               dif.DecAluOpQ102H, dif.DecBrTypeQ102H, dif.DecRs1Q102H, dif.DecRs2Q102H,
               dif.DecRdQ102H, dif.DecRs1DataQ102H, dif.DecRs2DataQ102H, dif.DecRegWrEnQ102H,
               dif.DecMemRdEnQ102H, dif.DecMemWrEnQ102H, dif.DecIllegalQ102H};
        n_cmp++;
        if (got !== 164'h0) begin
            n_bad++; $display("FAIL reset_fields got %h exp 0", got);
        end
        n_cmp++;
        if (dif.FetchReadyQ101H !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got %b exp 1", dif.FetchReadyQ101H);
        end
    endtask

    task automatic test_addi();
        fetch(32'h0050_0093, 32'h10);
        #1;
        n_cmp++;
        if (dif.FetchReadyQ101H !== 1'b1) begin
            n_bad++; $display("FAIL addi_ready got %b exp 1", dif.FetchReadyQ101H);
        end
        tick();
        dif.FetchValidQ101H = 1'b0;
        n_cmp++;
        if ({dif.DecValidQ102H, dif.DecPcQ102H} !== {1'b1, 32'h10}) begin
            n_bad++; $display("FAIL addi_valid_pc got %b/%h exp 1/10", dif.DecValidQ102H, dif.DecPcQ102H);
        end
        n_cmp++;
        if ({dif.DecOpcodeQ102H, dif.DecImmQ102H, dif.DecAluOpQ102H} !== {I_OP, 32'd5, ADD}) begin
            n_bad++; $display("FAIL addi_decode got %h/%h/%h", dif.DecOpcodeQ102H, dif.DecImmQ102H, dif.DecAluOpQ102H);
        end
        n_cmp++;
        if ({dif.DecRdQ102H, dif.DecRegWrEnQ102H, dif.DecRs1DataQ102H} !== {5'd1, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL addi_rd_wr_data got %0d/%b/%h exp 1/1/0", dif.DecRdQ102H, dif.DecRegWrEnQ102H, dif.DecRs1DataQ102H);
        end
    endtask

    task automatic test_bypass();
        fetch(32'h0001_0133, 32'h14);
        dif.WbEnQ105H   = 1'b1;
        dif.WbRdQ105H   = 5'd2;
        dif.WbDataQ105H = 32'hDEAD_BEEF;
        tick();
        set_idle();
        n_cmp++;
        if ({dif.DecValidQ102H, dif.DecRs1DataQ102H} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL bypass_rs1 got %b/%h exp 1/deadbeef", dif.DecValidQ102H, dif.DecRs1DataQ102H);
        end
    endtask

    task automatic test_stall();
        fetch(32'h0020_81B3, 32'h18);
        tick();
        dif.DecReadyQ103H = 1'b0;
        fetch(NOP_INST, 32'h1C);
        for (int cyc = 0; cyc < 3; cyc++) begin
            dif.WbEnQ105H   = (cyc == 1);
            dif.WbRdQ105H   = 5'd2;
            dif.WbDataQ105H = 32'h1234;
            #1;
            n_cmp++;
            if (dif.FetchReadyQ101H !== 1'b0) begin
                n_bad++; $display("FAIL stall_ready c%0d got %b exp 0", cyc, dif.FetchReadyQ101H);
            end
            tick();
            n_cmp++;
            if ({dif.DecValidQ102H, dif.DecPcQ102H, dif.DecRdQ102H} !== {1'b1, 32'h18, 5'd3}) begin
                n_bad++; $display("FAIL stall_hold c%0d got %b/%h/%0d exp 1/18/3", cyc, dif.DecValidQ102H, dif.DecPcQ102H, dif.DecRdQ102H);
            end
            n_cmp++;
            if (dif.DecRs2DataQ102H !== ((cyc == 0) ? 32'hDEAD_BEEF : 32'h1234)) begin
                n_bad++; $display("FAIL stall_rs2_data c%0d got %h", cyc, dif.DecRs2DataQ102H);
            end
        end
        dif.WbEnQ105H = 1'b0;
    endtask

    task automatic test_flush();
        fetch(32'h0030_0113, 32'h40);
        dif.FlushQ102H = 1'b1;
        tick();
        n_cmp++;
        if (dif.DecValidQ102H !== 1'b0) begin
            n_bad++; $display("FAIL flush_valid got %b exp 0", dif.DecValidQ102H);
        end
        set_idle();
        tick();
        n_cmp++;
        if (dif.DecValidQ102H !== 1'b0) begin
            n_bad++; $display("FAIL flush_after got %b exp 0", dif.DecValidQ102H);
        end
    endtask

    task automatic test_branch();
        fetch(32'hFE00_0EE3, 32'h20);
        tick();
        dif.FetchValidQ101H = 1'b0;
        n_cmp++;
        if ({dif.DecValidQ102H, dif.DecImmTypeQ102H, dif.DecImmQ102H} !== {1'b1, B_TYPE, 32'hFFFF_FFFC}) begin
            n_bad++; $display("FAIL branch_imm got %b/%h/%h exp 1/B/fffffffc", dif.DecValidQ102H, dif.DecImmTypeQ102H, dif.DecImmQ102H);
        end
        n_cmp++;
        if ({dif.DecAluOpQ102H, dif.DecBrTypeQ102H, dif.DecRegWrEnQ102H} !== {SUB, BEQ, 1'b0}) begin
            n_bad++; $display("FAIL branch_ctrl got %h/%h/%b", dif.DecAluOpQ102H, dif.DecBrTypeQ102H, dif.DecRegWrEnQ102H);
        end
    endtask

    task automatic test_illegal();
        fetch(32'h0000_A003, 32'h30);
        tick();
        n_cmp++;
        if ({dif.DecIllegalQ102H, dif.DecMemRdEnQ102H} !== 2'b01) begin
            n_bad++; $display("FAIL load_w_legal got %b/%b exp 0/1", dif.DecIllegalQ102H, dif.DecMemRdEnQ102H);
        end
        fetch(32'h0000_B003, 32'h34);
        tick();
        dif.FetchValidQ101H = 1'b0;
        n_cmp++;
        if ({dif.DecIllegalQ102H, dif.DecMemRdEnQ102H} !== {ILL_EN, !ILL_EN}) begin
            n_bad++; $display("FAIL load_f3_011 got %b/%b exp %b/%b", dif.DecIllegalQ102H, dif.DecMemRdEnQ102H, ILL_EN, !ILL_EN);
        end
    endtask

    task automatic test_back_to_back();
        logic [163:0] got, exp;
        logic [4:0]   r1, r2;
        for (int n = 0; n < 400; n++) begin
            dif.FetchValidQ101H = ($urandom_range(0, 3) != 0);
            dif.FetchInstQ101H  = rand_inst();
            dif.FetchPcQ101H    = $urandom & 32'hFFFF_FFFC;
            dif.DecReadyQ103H   = ($urandom_range(0, 2) != 0);
            dif.FlushQ102H      = ($urandom_range(0, 9) == 0);
            dif.WbEnQ105H       = ($urandom_range(0, 1) != 0);
            dif.WbRdQ105H       = 5'($urandom_range(0, 3));
            dif.WbDataQ105H     = $urandom;
            #1;
            n_cmp++;
            if (dif.FetchReadyQ101H !== (!m_valid || dif.DecReadyQ103H)) begin
                n_bad++; $display("FAIL rand_ready n%0d got %b exp %b", n, dif.FetchReadyQ101H, !m_valid || dif.DecReadyQ103H);
            end
            tick();
            n_cmp++;
            if (dif.DecValidQ102H !== m_valid) begin
                n_bad++; $display("FAIL rand_valid n%0d got %b exp %b", n, dif.DecValidQ102H, m_valid);
            end
            if (m_valid) begin
                r1  = m_inst[19:15];
                r2  = m_inst[24:20];
                got = {dif.DecPcQ102H, dif.DecOpcodeQ102H, dif.DecImmTypeQ102H, dif.DecImmQ102H,
                       dif.DecAluOpQ102H, dif.DecBrTypeQ102H, dif.DecRs1Q102H, dif.DecRs2Q102H,
                       dif.DecRdQ102H, dif.DecRs1DataQ102H, dif.DecRs2DataQ102H, dif.DecRegWrEnQ102H,
                       dif.DecMemRdEnQ102H, dif.DecMemWrEnQ102H, dif.DecIllegalQ102H};
                exp = {m_pc, m_inst[6:0], ref_immt(m_inst), ref_imm(m_inst), ref_alu(m_inst),
                       m_inst[14:12], r1, r2, m_inst[11:7],
                       (r1 == 5'd0) ? 32'h0 : rf_m[r1], (r2 == 5'd0) ? 32'h0 : rf_m[r2],
                       ref_wr(m_inst), (m_inst[6:0] == 7'h03) && !ref_ill(m_inst),
                       (m_inst[6:0] == 7'h23) && !ref_ill(m_inst), ref_ill(m_inst)};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++; $display("FAIL rand_fields n%0d inst %h got %h exp %h", n, m_inst, got, exp);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        set_idle();
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_bypass();
        test_stall();
        test_flush();
        test_branch();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
